// File: rtl/ppwm_pkg.sv
// Shared types and sizing helpers for the multi-channel serial-programmed PWM.
// Optional build macro: PPWM_FRAME_PARITY_EN adds a trailing even-parity bit to every frame.
package ppwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } rx_state_t;

    // A single channel still needs one address bit so the frame layout stays uniform.
    function automatic int ch_bits_f(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Bits shifted in after the start bit.
    function automatic int frame_len_f(input int num_ch, input int cnt_w);
`ifdef PPWM_FRAME_PARITY_EN
        return 2 + ch_bits_f(num_ch) + cnt_w;
`else
        return 1 + ch_bits_f(num_ch) + cnt_w;
`endif
    endfunction

endpackage

// File: rtl/ppwm_frame_rx.sv
// 1-wire frame receiver: start bit, imm, ch, value (MSB first), counted on valid cycles only.
// Optional build macro: PPWM_FRAME_PARITY_EN expects a trailing even-parity bit.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a valid cycle carrying a 1 (start bit)
//   ST_SHIFT  | shifting payload bits; holds indefinitely across gaps
//   ST_COMMIT | one cycle: fields are stable, top writes or rejects them
module ppwm_frame_rx
    import ppwm_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 10,
    localparam int CH_BITS      = ch_bits_f(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ser_data_i,
    input  logic                     ser_valid_i,
    output logic                     commit_o,
    output logic                     imm_o,
    output logic [CH_BITS-1:0]       ch_o,
    output logic [COUNTER_WIDTH-1:0] value_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int FRAME_LEN = frame_len_f(NUM_CH, COUNTER_WIDTH);
    localparam int BCNT_W    = $clog2(FRAME_LEN);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [BCNT_W-1:0]     bits_left;
    logic [FRAME_LEN-1:0]  sr;
    logic                  start_seen;
    logic                  par_bad;
    logic [CH_BITS:0]      ch_ext;

    assign start_seen = (state == ST_IDLE) && ser_valid_i && ser_data_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        commit_o  = 1'b0;
        busy_o    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ser_valid_i && ser_data_i) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy_o = 1'b1;
                if (ser_valid_i && (bits_left == '0)) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy_o    = 1'b1;
                commit_o  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift register and down-counting bit budget; terminal count 0 marks the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_left <= '0;
            sr        <= '0;
        end else if (start_seen) begin
            bits_left <= BCNT_W'(FRAME_LEN - 1);
        end else if ((state == ST_SHIFT) && ser_valid_i) begin
            sr        <= {sr[FRAME_LEN-2:0], ser_data_i};
            bits_left <= bits_left - BCNT_W'(1);
        end
    end

`ifdef PPWM_FRAME_PARITY_EN
    localparam int OFS = 1;
    assign par_bad = ^sr;
`else
    localparam int OFS = 0;
    assign par_bad = 1'b0;
`endif

    assign value_o = sr[OFS +: COUNTER_WIDTH];
    assign ch_o    = sr[OFS + COUNTER_WIDTH +: CH_BITS];
    assign imm_o   = sr[FRAME_LEN-1];

    // Widen before comparing so a power-of-two channel count does not collapse the check.
    assign ch_ext = {1'b0, ch_o};
    assign err_o  = par_bad || (ch_ext >= (CH_BITS + 1)'(NUM_CH));

endmodule

// File: rtl/ppwm_multi.sv
// Multi-channel PWM: one free-running period counter, per-channel shadow/active compare banks,
// serial frame programming. Shadow values reach the active bank on the counter wrap.
// Optional build macro: PPWM_FRAME_PARITY_EN (frames carry an even-parity bit).
module ppwm_multi
    import ppwm_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_data_i,
    input  logic              ser_valid_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              period_start_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CH_BITS = ch_bits_f(NUM_CH);

    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] shadow [NUM_CH];
    logic [COUNTER_WIDTH-1:0] active [NUM_CH];
    logic                     rx_commit;
    logic                     rx_imm;
    logic [CH_BITS-1:0]       rx_ch;
    logic [COUNTER_WIDTH-1:0] rx_value;
    logic                     rx_err;
    logic                     wr_ok;
    logic                     wrap;
    logic [NUM_CH-1:0]        hit;

    ppwm_frame_rx #(
        .NUM_CH        (NUM_CH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ser_data_i  (ser_data_i),
        .ser_valid_i (ser_valid_i),
        .commit_o    (rx_commit),
        .imm_o       (rx_imm),
        .ch_o        (rx_ch),
        .value_o     (rx_value),
        .err_o       (rx_err),
        .busy_o      (busy_o)
    );

    assign wr_ok          = rx_commit && !rx_err;
    assign frame_done_o   = wr_ok;
    assign frame_err_o    = rx_commit && rx_err;
    assign wrap           = (cnt == '1);
    assign period_start_o = !rst && (cnt == '0);

    // Per-channel write select for the frame being committed.
    always_comb begin
        hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = wr_ok && (rx_ch == CH_BITS'(c));
        end
    end

    // Free-running period counter; wraps naturally at 2**COUNTER_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + COUNTER_WIDTH'(1);
    end

    // Shadow/active banks; a commit landing on the wrap edge bypasses straight into active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= '0;
                active[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit[c]) shadow[c] <= rx_value;
                if (wrap)                   active[c] <= hit[c] ? rx_value : shadow[c];
                else if (hit[c] && rx_imm)  active[c] <= rx_value;
            end
        end
    end

    // Registered comparators, one cycle behind the counter on every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pwm_o[c] <= (cnt < active[c]);
            end
        end
    end

endmodule
